// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit common-anode 7-segment driver with frame-synchronous loads.
// Define SEG7_BLINK_EN to enable per-digit blinking selected by blink_mask.
module seg7_scan_driver #(
    parameter int N_DIGITS     = 4,
    parameter int DIV_COUNT    = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic [N_DIGITS-1:0]   blink_mask,
    output logic [0:6]            seg_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  upd_done
);
    localparam int PW = $clog2(DIV_COUNT);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int DW = 4 * N_DIGITS;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       active_q, active_d, pend_q, pend_d;
    logic                pflag_q, pflag_d;
    logic [0:6]          seg_n_q, seg_n_d;
    logic [N_DIGITS-1:0] an_n_q, an_n_d;
    logic                upd_q, upd_d;
    logic                wrap, last, frame, lit, blink_off, lz_run;
    logic [3:0]          nib;
    logic [N_DIGITS-1:0] lz_mask;

    function automatic logic [0:6] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'h01;
            4'h1: glyph = 7'h4F;
            4'h2: glyph = 7'h12;
            4'h3: glyph = 7'h06;
            4'h4: glyph = 7'h4C;
            4'h5: glyph = 7'h24;
            4'h6: glyph = 7'h20;
            4'h7: glyph = 7'h0F;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h0C;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h60;
            4'hC: glyph = 7'h31;
            4'hD: glyph = 7'h42;
            4'hE: glyph = 7'h30;
            default: glyph = 7'h38;
        endcase
    endfunction

    // lz_mask[k] is set when nibbles k..top are all zero; digit 0 always stays visible
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            lz_run     = lz_run & (active_q[4*k +: 4] == 4'h0);
            lz_mask[k] = lz_run;
        end
    end

    always_comb begin
        wrap     = presc_q == PW'(DIV_COUNT - 1);
        last     = idx_q == IW'(N_DIGITS - 1);
        frame    = wrap && last;
        presc_d  = wrap ? '0 : presc_q + 1'b1;
        idx_d    = !wrap ? idx_q : last ? '0 : idx_q + 1'b1;
        pend_d   = load ? data_in : pend_q;
        pflag_d  = !frame && (pflag_q || load);
        active_d = !frame ? active_q : load ? data_in : pflag_q ? pend_q : active_q;
        upd_d    = frame && (load || pflag_q);
        nib      = 4'(active_q >> {idx_q, 2'b00});
        lit      = int'(presc_q) >= BLANK_CYCLES && !(lz_blank && lz_mask[idx_q])
                   && !(blink_off && blink_mask[idx_q]);
        an_n_d   = lit ? ~(N_DIGITS'(1) << idx_q) : '1;
        seg_n_d  = lit ? glyph(nib) : 7'h7F;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            idx_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            pflag_q  <= 1'b0;
            seg_n_q  <= 7'h7F;
            an_n_q   <= '1;
            upd_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pflag_q  <= pflag_d;
            seg_n_q  <= seg_n_d;
            an_n_q   <= an_n_d;
            upd_q    <= upd_d;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES) + 1;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bon_q, bon_d;
    logic          bflip;

    always_comb begin
        bflip  = frame && bcnt_q == BW'(BLINK_FRAMES - 1);
        bcnt_d = !frame ? bcnt_q : bflip ? '0 : bcnt_q + 1'b1;
        bon_d  = bflip ? !bon_q : bon_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q <= '0;
            bon_q  <= 1'b1;
        end else begin
            bcnt_q <= bcnt_d;
            bon_q  <= bon_d;
        end
    end

    assign blink_off = !bon_q;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    assign blink_off = 1'b0;
`endif

    assign seg_n    = seg_n_q;
    assign an_n     = an_n_q;
    assign upd_done = upd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, glyphs, load handshake, blanking and reset.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [0:6]  seg_n;
    logic [3:0]  an_n;
    logic        upd_done;

    int n_cmp = 0;
    int n_err = 0;
    int lit_cnt [4];
    int seg_var [4];
    logic [6:0] seg_first [4];
    int blank_bad, upd_cnt, order_err, d0_4f, found;
    int d1_on, d1_off, others;

    seg7_scan_driver #(
        .N_DIGITS(4), .DIV_COUNT(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .lz_blank(lz_blank),
        .blink_mask(blink_mask), .seg_n(seg_n), .an_n(an_n), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scan(input int cycles);
        logic [6:0] s;
        int d, prev;
        prev = -1;
        blank_bad = 0; upd_cnt = 0; order_err = 0; d0_4f = 0;
        for (int k = 0; k < 4; k++) begin
            lit_cnt[k] = 0; seg_var[k] = 0; seg_first[k] = 7'h7F;
        end
        repeat (cycles) begin
            @(negedge clk);
            s = seg_n;
            if (upd_done) upd_cnt++;
            d = -1;
            for (int k = 0; k < 4; k++) if (an_n == ~(4'b1 << k)) d = k;
            if (an_n == 4'hF) begin
                if (s != 7'h7F) blank_bad++;
            end else if (d < 0) begin
                blank_bad++;
            end else begin
                if (lit_cnt[d] == 0) seg_first[d] = s;
                else if (s != seg_first[d]) seg_var[d]++;
                lit_cnt[d]++;
                if (d == 0 && s == 7'h4F) d0_4f++;
                if (prev >= 0 && d != prev && d != (prev + 1) % 4) order_err++;
                prev = d;
            end
        end
    endtask

    task automatic wait_upd(input int limit);
        found = int'(upd_done);
        for (int i = 0; i < limit && found == 0; i++) begin
            @(negedge clk);
            if (upd_done) found = 1;
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        data_in = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_seg", seg_n, 7'h7F);
        chk("rst_an", an_n, 4'hF);
        chk("rst_upd", upd_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_blank_an", an_n, 4'hF);
        @(negedge clk);
        chk("first_slot_an", an_n, 4'hE);
        chk("first_slot_seg", seg_n, 7'h01);

        do_load(16'h12AF);
        wait_upd(40);
        chk("12af_upd_seen", found, 1);
        scan(16);
        chk("12af_d0_seg", seg_first[0], 7'h38);
        chk("12af_d1_seg", seg_first[1], 7'h08);
        chk("12af_d2_seg", seg_first[2], 7'h12);
        chk("12af_d3_seg", seg_first[3], 7'h4F);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("12af_lit%0d", k), lit_cnt[k], 3);
            chk($sformatf("12af_var%0d", k), seg_var[k], 0);
        end
        chk("12af_blank", blank_bad, 0);
        chk("12af_order", order_err, 0);
        chk("12af_no_extra_upd", upd_cnt, 0);

        do_load(16'h1111);
        do_load(16'h2222);
        scan(40);
        chk("last_load_single_upd", upd_cnt, 1);
        chk("1111_never_shown", d0_4f, 0);
        scan(16);
        for (int k = 0; k < 4; k++) chk($sformatf("2222_seg%0d", k), seg_first[k], 7'h12);
        chk("2222_lit0", lit_cnt[0], 3);

        lz_blank = 1'b1;
        do_load(16'h0040);
        wait_upd(40);
        chk("0040_upd_seen", found, 1);
        scan(16);
        chk("0040_d0_seg", seg_first[0], 7'h01);
        chk("0040_d1_seg", seg_first[1], 7'h4C);
        chk("0040_lit0", lit_cnt[0], 3);
        chk("0040_lit1", lit_cnt[1], 3);
        chk("0040_lit2", lit_cnt[2], 0);
        chk("0040_lit3", lit_cnt[3], 0);
        chk("0040_blank", blank_bad, 0);

        do_load(16'h0000);
        wait_upd(40);
        chk("0000_upd_seen", found, 1);
        scan(16);
        chk("0000_d0_seg", seg_first[0], 7'h01);
        chk("0000_lit0", lit_cnt[0], 3);
        chk("0000_lit_hi", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);
        chk("idle_no_upd", upd_cnt, 0);

        repeat (15) @(negedge clk);
        do_load(16'h0009);
        chk("boundary_load_upd", upd_done, 1'b1);
        @(negedge clk);
        chk("boundary_blank_an", an_n, 4'hF);
        @(negedge clk);
        chk("boundary_d0_an", an_n, 4'hE);
        chk("boundary_d0_seg", seg_n, 7'h0C);

        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", seg_n, 7'h7F);
        chk("async_rst_an", an_n, 4'hF);
        chk("async_rst_upd", upd_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerst_blank_an", an_n, 4'hF);
        @(negedge clk);
        chk("rerst_d0_an", an_n, 4'hE);
        chk("rerst_d0_seg", seg_n, 7'h01);
        scan(16);
        chk("rerst_active_zero", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);

        lz_blank = 1'b0;
        blink_mask = 4'b0010;
        do_load(16'h12AF);
        wait_upd(40);
        chk("blink_upd_seen", found, 1);
        d1_on = 0; d1_off = 0; others = 0;
        repeat (4) begin
            scan(16);
            if (lit_cnt[1] == 3) d1_on++;
            if (lit_cnt[1] == 0) d1_off++;
            others += lit_cnt[0] + lit_cnt[2] + lit_cnt[3];
        end
        chk("blink_others_lit", others, 36);
`ifdef SEG7_BLINK_EN
        chk("blink_d1_on_frames", d1_on, 2);
        chk("blink_d1_off_frames", d1_off, 2);
`else
        chk("noblink_d1_on_frames", d1_on, 4);
        chk("noblink_d1_off_frames", d1_off, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
